// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU control codes and forwarding-select encoding for the
// ID/EX operand stage.
package id_ex_operand_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source bypass selector: the youngest matching producer wins, and
// register 0 always reads as zero.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] src_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] fwd
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (exmem_reg_write && (exmem_rd == src))
        sel = FWD_EXMEM;
      else if (memwb_reg_write && (memwb_rd == src))
        sel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: fwd = exmem_result;
      FWD_MEMWB: fwd = memwb_result;
      default:   fwd = (src == '0) ? '0 : src_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the execute ALU, with EX/MEM and MEM/WB
// operand forwarding and load-use hazard detection.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [1:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [1:0]        alu_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              load_use_hazard
);

  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic              use_imm_q, reg_write_q, mem_read_q;
  logic [1:0]        alu_ctrl_q;
  logic [DATA_W-1:0] fwd1, fwd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_ctrl_q  <= 2'b00;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      alu_ctrl_q  <= id_alu_ctrl;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (stall) begin
      // Refresh operands from the bypass so a producer retiring mid-stall is kept.
      rs1_data_q <= fwd1;
      rs2_data_q <= fwd2;
    end else begin
      ex_valid    <= id_valid;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      alu_ctrl_q  <= id_alu_ctrl;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end
  end

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .src             (rs1_q),
    .src_data        (rs1_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd             (fwd1)
  );

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .src             (rs2_q),
    .src_data        (rs2_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd             (fwd2)
  );

  assign alu_op1       = fwd1;
  assign alu_op2       = use_imm_q ? imm_q : fwd2;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ex_valid & reg_write_q;
  assign ex_mem_read   = ex_valid & mem_read_q;
  assign ex_store_data = fwd2;

  assign load_use_hazard = id_valid & ex_mem_read & (rd_q != '0) &
                           ((rd_q == id_rs1) | (rd_q == id_rs2));

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand forwarding; sits directly upstream of the execute-stage ALU.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards by forwarding EX/MEM and MEM/WB results.
- Drives the ALU's two 32-bit operands and 2-bit control code.
- Flags load-use hazards to the hazard/stall logic.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width (register 0 hardwired zero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hold the stage contents.
- flush  in  1  replace captured instruction with a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source indices.
- id_rd  in  REG_AW  destination index.
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_use_imm  in  1  operand2 = immediate.
- id_alu_ctrl  in  2  00 add, 01 and, 10 or, 11 reserved.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- exmem_reg_write  in  1  EX/MEM write enable.
- exmem_rd  in  REG_AW  EX/MEM destination.
- exmem_result  in  DATA_W  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB write enable.
- memwb_rd  in  REG_AW  MEM/WB destination.
- memwb_result  in  DATA_W  MEM/WB result.
- alu_op1, alu_op2  out  DATA_W  ALU operands.
- alu_ctrl  out  2  ALU control.
- ex_rd  out  REG_AW  destination passed on.
- ex_reg_write  out  1  qualified by ex_valid.
- ex_mem_read  out  1  qualified by ex_valid.
- ex_store_data  out  DATA_W  forwarded rs2 value.
- ex_valid  out  1  stage holds a real instruction.
- load_use_hazard  out  1  request ID/IF stall.

Behaviour:
- Register update priority each rising edge: rst (async) > flush > stall > load.
- Reset: all stored fields 0, including ex_valid.
  - Outputs become alu_op1 = 0, alu_op2 = 0, alu_ctrl = 00, ex_rd = 0, ex_reg_write = 0, ex_mem_read = 0, ex_store_data = 0, load_use_hazard = 0.
  - Reset mid-stall or mid-flush discards the instruction.
- Flush: ex_valid <= 0; reg_write/mem_read <= 0.
  - Other fields may load, but bubble outputs (ex_reg_write, ex_mem_read) must be 0.
- Load: all id_* fields captured; ex_valid <= id_valid.
- Stall (no flush): indices, control and immediate held.
  - Stored rs1/rs2 data are overwritten with the currently forwarded values (fwd1, fwd2).
  - A producer retiring during the stall is therefore not lost.
- Forwarding (combinational from stored indices and current bypass inputs), per source s:
  - EX/MEM forwards if exmem_reg_write and exmem_rd == s and s != 0.
  - Otherwise MEM/WB forwards if memwb_reg_write and memwb_rd == s and s != 0.
  - Otherwise the stored register data is used.
  - EX/MEM wins when both match (youngest producer).
- Source 0 always yields 0, regardless of stored data.
- alu_op1 = fwd1.
- alu_op2 = stored immediate if use_imm, else fwd2.
- ex_store_data = fwd2 always.
- Latency: ID fields appear on outputs one cycle after capture; forwarding adds zero cycles.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2), gated by id_valid. Purely combinational.
- Reserved alu_ctrl 11 is passed through unchanged.

Decomposition:
- Shared package: DATA_W/REG_AW defaults; ALU control codes ALU_ADD = 00, ALU_AND = 01, ALU_OR = 10; forwarding-select encoding FWD_REG, FWD_EXMEM, FWD_MEMWB.
- One sub-module: fwd_mux.
  - Takes one source index, stored data, and both bypass buses; returns the forwarded value.
  - Instantiated twice.
- Hazard compare stays inline.

Test Plan:
- Reset mid-operation: assert rst with ex_valid = 1 → all outputs 0 immediately (async); first load after release captures normally.
- Basic capture: id_rs1_data = 5, id_rs2_data = 7, alu_ctrl = 00, no matches → next cycle alu_op1 = 5, alu_op2 = 7, alu_ctrl = 00, ex_valid = 1.
- Forward priority: stored rs1 = 3; exmem_rd = memwb_rd = 3 with results 0xAA and 0xBB, both write-enabled → alu_op1 = 0xAA. Drop exmem_reg_write → alu_op1 = 0xBB.
- Register 0: rs1 = 0, exmem_rd = 0, exmem_result = 0x55 → alu_op1 = 0.
- Stall capture: stall = 1, memwb_rd = rs2 = 4, memwb_result = 0x1234 for one cycle, then memwb_reg_write = 0 → ex_store_data and alu_op2 remain 0x1234 for the rest of the stall.
- Load-use and flush: EX holds a load with rd = 6, ID rs2 = 6 → load_use_hazard = 1. flush = 1 → next cycle ex_valid = 0, ex_reg_write = 0, load_use_hazard = 0.
